// File: rtl/truth_table_sweeper_if.sv
// rtl/truth_table_sweeper_if.sv - stimulus/capture signal bundle for the truth-table sweeper
//
// Purpose: groups the sweep handshake, stimulus vector and capture results.
//   master modport: the side that requests sweeps and evaluates the function
//   slave  modport: the sweeper itself
// Signals:
//   start        sweep request (sampled only while the sweeper is idle)
//   f_in         function output, combinational from vars_out
//   vars_out     input vector to the function, MSB = variable a
//   m_idx        current minterm index (same value as vars_out)
//   busy, done   sweep in progress / one-cycle completion pulse
//   table_out    captured truth table, bit i = f(minterm i)
//   ones_count   number of true minterms
//   mismatch     captured table differs from golden (checker builds only)
//   mismatch_idx lowest differing minterm (checker builds only)
interface truth_table_sweeper_if #(
    parameter int N_VARS = 4
);
    logic                    start;
    logic                    f_in;
    logic [N_VARS-1:0]       vars_out;
    logic [N_VARS-1:0]       m_idx;
    logic                    busy;
    logic                    done;
    logic [(2**N_VARS)-1:0]  table_out;
    logic [N_VARS:0]         ones_count;
    logic                    mismatch;
    logic [N_VARS-1:0]       mismatch_idx;

    modport master (
        output start, f_in,
        input  vars_out, m_idx, busy, done, table_out, ones_count, mismatch, mismatch_idx
    );

    modport slave (
        input  start, f_in,
        output vars_out, m_idx, busy, done, table_out, ones_count, mismatch, mismatch_idx
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - clocked minterm sweep and truth-table capture for N-input functions
//
// Purpose: walks vars_out through minterms 0..2**N_VARS-1 (a = MSB), holds each
// for SETTLE+1 cycles, samples f_in on the last of them, and assembles the
// truth table plus a count of true minterms. start/busy/done form the handshake.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   sw     truth_table_sweeper_if.slave (start, f_in in; vector, status, results out)
// Optional feature: define SOP_CHECK_EN to compare the captured table with
// EXPECTED on entry to DONE (mismatch, mismatch_idx). Without it both are 0.
module truth_table_sweeper #(
    parameter int                     N_VARS   = 4,
    parameter int                     SETTLE   = 1,
    parameter logic [(2**N_VARS)-1:0] EXPECTED = 16'h3C00
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_sweeper_if.slave  sw
);
    localparam int TBL = 2**N_VARS;
    localparam logic [N_VARS-1:0] LAST_IDX = N_VARS'(TBL - 1);
    localparam logic [3:0]        SETTLE_W = 4'(SETTLE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_VARS-1:0] m_idx_q, m_idx_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [TBL-1:0]    table_q, table_d;
    logic [N_VARS:0]   ones_q, ones_d;

`ifdef SOP_CHECK_EN
    logic              mm_q, mm_d;
    logic [N_VARS-1:0] mm_idx_q, mm_idx_d;
    logic [TBL-1:0]    diff;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            m_idx_q  <= '0;
            cnt_q    <= '0;
            table_q  <= '0;
            ones_q   <= '0;
`ifdef SOP_CHECK_EN
            mm_q     <= 1'b0;
            mm_idx_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            m_idx_q  <= m_idx_d;
            cnt_q    <= cnt_d;
            table_q  <= table_d;
            ones_q   <= ones_d;
`ifdef SOP_CHECK_EN
            mm_q     <= mm_d;
            mm_idx_q <= mm_idx_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        m_idx_d  = m_idx_q;
        cnt_d    = cnt_q;
        table_d  = table_q;
        ones_d   = ones_q;
`ifdef SOP_CHECK_EN
        mm_d     = mm_q;
        mm_idx_d = mm_idx_q;
        diff     = '0;
`endif
        case (state_q)
            IDLE: begin
                if (sw.start) begin
                    state_d = DRIVE;
                    m_idx_d = '0;
                    cnt_d   = '0;
                    table_d = '0;
                    ones_d  = '0;
`ifdef SOP_CHECK_EN
                    mm_d     = 1'b0;
                    mm_idx_d = '0;
`endif
                end
            end
            DRIVE: begin
                if (cnt_q == SETTLE_W) begin
                    // Last cycle of this minterm: the vector has been stable for SETTLE cycles.
                    table_d[m_idx_q] = sw.f_in;
                    ones_d           = ones_q + (N_VARS+1)'(sw.f_in);
                    cnt_d            = '0;
                    if (m_idx_q == LAST_IDX) begin
                        state_d = DONE;
                        // Vector parks at 0 once the sweep is over; the last index never wraps.
                        m_idx_d = '0;
`ifdef SOP_CHECK_EN
                        diff     = table_d ^ EXPECTED;
                        mm_d     = |diff;
                        mm_idx_d = '0;
                        // Scan downwards so the lowest differing minterm is the one kept.
                        for (int i = TBL - 1; i >= 0; i--) begin
                            if (diff[i]) begin
                                mm_idx_d = N_VARS'(i);
                            end
                        end
`endif
                    end else begin
                        m_idx_d = m_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sw.vars_out   = m_idx_q;
    assign sw.m_idx      = m_idx_q;
    assign sw.busy       = (state_q == DRIVE);
    assign sw.done       = (state_q == DONE);
    assign sw.table_out  = table_q;
    assign sw.ones_count = ones_q;

`ifdef SOP_CHECK_EN
    assign sw.mismatch     = mm_q;
    assign sw.mismatch_idx = mm_idx_q;
`else
    // Golden table only matters to the checker; folds to constant 0 here.
    assign sw.mismatch     = 1'b0 & (^EXPECTED);
    assign sw.mismatch_idx = '0;
`endif
endmodule
